// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message-schedule datapath.
//   - Small-sigma rotate/shift amounts (sigma0: 7/18/3, sigma1: 17/19/10)
//   - SCHED_WIN: depth of the sliding schedule window (16 words)
//   - sched_state_t: expander FSM state encoding
//   - bswap32: byte reversal used when MSG_SCHED_BSWAP_EN is defined
package sha256_pkg;

    localparam int unsigned SIG0_ROT_A = 7;
    localparam int unsigned SIG0_ROT_B = 18;
    localparam int unsigned SIG0_SHR   = 3;
    localparam int unsigned SIG1_ROT_A = 17;
    localparam int unsigned SIG1_ROT_B = 19;
    localparam int unsigned SIG1_SHR   = 10;

    localparam int unsigned SCHED_WIN = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StEmit
    } sched_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the block source / round stage and the schedule expander.
//   slave  : expander side (consumes start/in_*/w_ready, drives in_ready/w_*/busy/done)
//   master : environment side (mirror image)
interface sha256_msg_schedule_if;

    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        w_valid;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        w_ready;
    logic        busy;
    logic        done;

    modport slave (
        input  start, in_valid, in_data, w_ready,
        output in_ready, w_valid, w_data, w_idx, busy, done
    );

    modport master (
        output start, in_valid, in_data, w_ready,
        input  in_ready, w_valid, w_data, w_idx, busy, done
    );

endinterface

// File: rtl/rotr.sv
// Constant-amount rotate right.
//   x_i : input word
//   y_o : x_i rotated right by Amount bits
module rotr #(
    parameter int unsigned Width  = 32,
    parameter int unsigned Amount = 1
) (
    input  logic [Width-1:0] x_i,
    output logic [Width-1:0] y_o
);

    assign y_o = (x_i >> Amount) | (x_i << (Width - Amount));

endmodule

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: ROTR(RotA) ^ ROTR(RotB) ^ SHR(Shr).
//   x_i : input word
//   y_o : sigma(x_i)
module sha256_small_sigma #(
    parameter int unsigned RotA = 7,
    parameter int unsigned RotB = 18,
    parameter int unsigned Shr  = 3
) (
    input  logic [31:0] x_i,
    output logic [31:0] y_o
);

    logic [31:0] rot_a;
    logic [31:0] rot_b;

    rotr #(.Width(32), .Amount(RotA)) u_rot_a (.x_i(x_i), .y_o(rot_a));
    rotr #(.Width(32), .Amount(RotB)) u_rot_b (.x_i(x_i), .y_o(rot_b));

    assign y_o = rot_a ^ rot_b ^ (x_i >> Shr);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander. Loads 16 words of a block, then streams
// W[0..ROUNDS-1] one word per handshake from a 16-word sliding window.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : sha256_msg_schedule_if.slave (start, in_*, w_*, busy, done)
// Configuration:
//   MSG_SCHED_BSWAP_EN defined -> each input word is byte-reversed before storage.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64  // legal range 16..64
) (
    input  logic                     clk,
    input  logic                     rst,
    sha256_msg_schedule_if.slave     bus
);

    sched_state_t state_q;
    logic [31:0]  win_q [SCHED_WIN];
    logic [3:0]   cnt_q;
    logic [5:0]   t_q;
    logic         done_q;

    logic [31:0]  sigma0;
    logic [31:0]  sigma1;
    logic [31:0]  w_next;
    logic [31:0]  in_word;
    logic         last_word;

`ifdef MSG_SCHED_BSWAP_EN
    assign in_word = bswap32(bus.in_data);
`else
    assign in_word = bus.in_data;
`endif

    // win_q[0] is W[t]; win_q[1], win_q[9], win_q[14] are W[t+1], W[t+9], W[t+14],
    // so the appended word is W[t+16].
    sha256_small_sigma #(
        .RotA(SIG0_ROT_A), .RotB(SIG0_ROT_B), .Shr(SIG0_SHR)
    ) u_sigma0 (
        .x_i(win_q[1]),
        .y_o(sigma0)
    );

    sha256_small_sigma #(
        .RotA(SIG1_ROT_A), .RotB(SIG1_ROT_B), .Shr(SIG1_SHR)
    ) u_sigma1 (
        .x_i(win_q[14]),
        .y_o(sigma1)
    );

    assign w_next    = sigma1 + win_q[9] + sigma0 + win_q[0];
    assign last_word = (t_q == 6'(ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < SCHED_WIN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StLoad;
                        cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        win_q[cnt_q] <= in_word;
                        cnt_q        <= cnt_q + 4'd1;
                        if (cnt_q == 4'(SCHED_WIN - 1)) begin
                            state_q <= StEmit;
                            t_q     <= '0;
                        end
                    end
                end
                StEmit: begin
                    if (bus.w_ready) begin
                        for (int i = 0; i < SCHED_WIN - 1; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[SCHED_WIN-1] <= w_next;
                        if (last_word) begin
                            state_q <= StIdle;
                            t_q     <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            t_q <= t_q + 6'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are pure decodes of registered state; data is zeroed when not valid.
    assign bus.in_ready = (state_q == StLoad);
    assign bus.w_valid  = (state_q == StEmit);
    assign bus.w_data   = (state_q == StEmit) ? win_q[0] : '0;
    assign bus.w_idx    = (state_q == StEmit) ? t_q : '0;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: a reference schedule is pushed into a
// scoreboard when a block is loaded and popped on every output handshake.
module tb_sha256_msg_schedule;

    localparam int unsigned ROUNDS = 64;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        exp_q [$];
    logic [31:0] msg [16];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rot(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rot(x, 7) ^ rot(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rot(x, 17) ^ rot(x, 19) ^ (x >> 10);
    endfunction

    // Word as presented on in_data so that the stored (logical) word is x.
    function automatic logic [31:0] present(input logic [31:0] x);
`ifdef MSG_SCHED_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
    endtask

    task automatic push_block();
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = msg[t];
        for (int t = 16; t < 64; t++) begin
            w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        end
        for (int t = 0; t < ROUNDS; t++) exp_q.push_back({6'(t), w[t]});
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_eq({tag, "_w_valid"},  32'(bus.w_valid),  32'd0);
        check_eq({tag, "_w_data"},   bus.w_data,        32'd0);
        check_eq({tag, "_w_idx"},    32'(bus.w_idx),    32'd0);
        check_eq({tag, "_busy"},     32'(bus.busy),     32'd0);
        check_eq({tag, "_done"},     32'(bus.done),     32'd0);
    endtask

    // Called at a negedge with the DUT idle.
    task automatic start_block();
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("start_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("start_busy",     32'(bus.busy),     32'd1);
    endtask

    task automatic load_block(input bit throttle);
        bit accepted;
        bit acc;
        bit toggle;
        int guard;
        toggle = 1'b0;
        push_block();
        for (int i = 0; i < 16; i++) begin
            accepted = 1'b0;
            guard    = 0;
            while (!accepted && guard < 50) begin
                guard++;
                bus.in_valid = !(throttle && toggle);
                bus.in_data  = present(msg[i]);
                toggle       = ~toggle;
                acc          = bus.in_valid && bus.in_ready;
                @(posedge clk);
                @(negedge clk);
                if (acc) accepted = 1'b1;
            end
            if (!accepted) check_eq("load_timeout", 32'(accepted), 32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic run_emit(input int stall_at, input int stall_len, input int rst_at,
                            input bit poke, input bit abc);
        int   stall_cnt;
        int   guard;
        bit   fin;
        exp_t e;
        stall_cnt = 0;
        guard     = 0;
        fin       = 1'b0;
        check_eq("emit_start_valid", 32'(bus.w_valid), 32'd1);
        while (!fin && guard < 400) begin
            guard++;
            if (rst_at >= 0 && bus.w_valid && 32'(bus.w_idx) == rst_at) begin
                rst = 1'b1;
                #1;
                check_reset("mid_emit_rst");
                exp_q.delete();
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                bus.w_ready = 1'b0;
                return;
            end
            if (poke) begin
                bus.start    = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
                check_eq("poke_in_ready", 32'(bus.in_ready), 32'd0);
            end
            if (bus.w_valid && 32'(bus.w_idx) == stall_at && stall_cnt < stall_len) begin
                bus.w_ready = 1'b0;
                stall_cnt++;
                if (exp_q.size() > 0) begin
                    check_eq("stall_idx",  32'(bus.w_idx), 32'(exp_q[0].idx));
                    check_eq("stall_data", bus.w_data,     exp_q[0].data);
                end
            end else begin
                bus.w_ready = 1'b1;
            end
            if (bus.w_valid && bus.w_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                    fin = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("w_data[%0d]", e.idx), bus.w_data, e.data);
                    check_eq($sformatf("w_idx[%0d]", e.idx), 32'(bus.w_idx), 32'(e.idx));
                    if (abc && e.idx == 6'd16) check_eq("abc_w16", bus.w_data, 32'h61626380);
                    if (abc && e.idx == 6'd17) check_eq("abc_w17", bus.w_data, 32'h000F0000);
                    if (32'(e.idx) == ROUNDS - 1) fin = 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.w_ready  = 1'b0;
        if (!fin) check_eq("emit_timeout", 32'(fin), 32'd1);
        check_eq("done_pulse",    32'(bus.done),    32'd1);
        check_eq("done_busy",     32'(bus.busy),    32'd0);
        check_eq("done_w_valid",  32'(bus.w_valid), 32'd0);
        check_eq("sb_empty",      32'(exp_q.size()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(bus.done), 32'd0);
        check_eq("idle_in_ready",  32'(bus.in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.w_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // in_valid while idle must not consume anything
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("idle_ignore_busy", 32'(bus.busy), 32'd0);

        set_abc();
        start_block();
        load_block(1'b0);
        run_emit(-1, 0, -1, 1'b0, 1'b1);

        set_random();
        start_block();
        load_block(1'b1);
        run_emit(-1, 0, -1, 1'b0, 1'b0);

        set_abc();
        start_block();
        load_block(1'b0);
        run_emit(20, 5, -1, 1'b0, 1'b1);

        set_abc();
        start_block();
        load_block(1'b0);
        run_emit(-1, 0, 30, 1'b0, 1'b1);
        check_reset("post_rst");

        set_abc();
        start_block();
        load_block(1'b0);
        run_emit(-1, 0, -1, 1'b0, 1'b1);

        set_random();
        start_block();
        load_block(1'b0);
        run_emit(-1, 0, -1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message-schedule expander for the Bitcoin hashing datapath. It accepts one 512-bit block as 16 32-bit words and streams the 64-entry schedule W[0..63] to the compression round stage. Expansion uses the small-sigma functions, which are built from the existing `rotr` rotate block. The round stage consumes W[t] one word per handshake.

## Interface
- `ROUNDS`, default 64: number of schedule words emitted. Legal range 16..64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a block. Sampled only in IDLE.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  32  message word, W[0] first.
- `in_ready`  out  1  expander accepts a word this cycle.
- `w_valid`  out  1  `w_data`/`w_idx` are valid.
- `w_data`  out  32  schedule word W[w_idx].
- `w_idx`  out  6  schedule index t.
- `w_ready`  in  1  downstream accepts W[t].
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, LOAD, EMIT.
- IDLE:
  - `start`=1 → LOAD; load counter cleared.
  - `start` is ignored in LOAD and EMIT.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid && in_ready` writes `in_data` to window slot `cnt` and increments `cnt`.
  - The 16th accept → EMIT, with t=0.
- EMIT:
  - `w_valid`=1, `w_data`=win[0], `w_idx`=t.
  - On `w_valid && w_ready`:
    - The window shifts down: win[i] ← win[i+1].
    - win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0], taken mod 2^32.
    - t increments.
  - When t = ROUNDS-1 is accepted: → IDLE, and `done`=1 on the next cycle.
- Small sigma functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Arithmetic: all adds are 32-bit, with carries discarded.
- The window append for t ≥ 48 is computed but never emitted.
- Backpressure: while `w_valid && !w_ready`, `w_data`, `w_idx` and the window hold stable.
- `in_valid` outside LOAD is ignored. No word is consumed there.

## Timing
- Reset values:
  - `in_ready`=0, `w_valid`=0, `w_data`=0, `w_idx`=0, `busy`=0, `done`=0.
  - State = IDLE; window and counters cleared.
- `start` at edge N → `in_ready`=1 from cycle N+1.
- The 16th input accept at edge M → `w_valid`=1 with W[0] from cycle M+1.
- With `w_ready` held high: one word per cycle, so ROUNDS cycles in EMIT.
- Last accept at edge K → `done`=1 in cycle K+1 and `busy`=0 in cycle K+1. `start` is accepted from cycle K+1.
- `rst` asserted mid-LOAD or mid-EMIT: outputs return to reset values immediately, and partial block data is discarded.
- The next-word computation is combinational from window registers. It must close timing inside one cycle.

## Configuration
- `MSG_SCHED_BSWAP_EN` defined: each `in_data` is byte-reversed before the window write. This suits little-endian Bitcoin header words.
- `MSG_SCHED_BSWAP_EN` undefined: words are stored as presented, big-endian per FIPS 180-4.

## Structure
- Shared package `sha256_pkg` holds:
  - Sigma rotate/shift constants (7, 18, 3, 17, 19, 10).
  - `SCHED_WIN` = 16.
  - State encoding typedef `sched_state_t`.
- Sub-module `sha256_small_sigma`:
  - Parameters: two rotate amounts and one shift amount.
  - Built from two `rotr` instances plus a logical shift and a 3-way XOR.
  - Instantiated twice, once as σ0 and once as σ1.

## Test plan
- "abc" block, no bswap:
  - Stimulus: 0x61626380, then 14 × 0x0, then 0x00000018; `w_ready`=1.
  - Response: W16=0x61626380, W17=0x000F0000, `w_idx` runs 0..63, `done` one cycle after idx 63.
- Input backpressure: `in_valid` toggled every other cycle during LOAD → same W stream as the unthrottled case, with the EMIT start delayed accordingly.
- Output backpressure: `w_ready` low for 5 cycles at t=20 → `w_data`/`w_idx` hold W20/20 stable, and the stream resumes unchanged.
- Reset at t=30: EMIT state → all outputs at reset values. A new "abc" block afterwards → W16=0x61626380 again.
- `start` pulsed during EMIT, and `in_valid` high during EMIT → no effect: `in_ready` stays 0 and the stream is unchanged.
- `MSG_SCHED_BSWAP_EN` defined: inputs 0x80636261, 14 × 0x0, 0x18000000 → W0=0x61626380, W17=0x000F0000.
